// File: rtl/contador_pkg.sv
// Shared types and helpers for the multi-channel object counter.
package contador_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    FULL = 1'b1
  } batchState_e;

  function automatic int unsigned debCycles(input int unsigned clockFreq,
                                            input int unsigned debounceMs);
    return clockFreq / 1000 * debounceMs;
  endfunction

  function automatic int unsigned selWidth(input int unsigned nCh);
    return (nCh > 1) ? $clog2(nCh) : 1;
  endfunction

  function automatic longint unsigned satAdd(input longint unsigned a,
                                             input longint unsigned b,
                                             input longint unsigned maxVal);
    longint unsigned sum;
    sum = a + b;
    return (sum > maxVal) ? maxVal : sum;
  endfunction

endpackage

// File: rtl/antirrebote_sync.sv
// Two-flop synchroniser, stability-time debouncer and one-cycle rise pulse
// for a single asynchronous level input.
module antirrebote_sync #(
  parameter int unsigned DEB_CYC = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic rise_o
);

  localparam int unsigned CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  logic sync1_q, sync2_q;
  logic clean_q, clean_d;
  logic cleanDly_q;
  logic [CW-1:0] stable_q, stable_d;

  // Any cycle where the synchronised level matches the clean level restarts the count
  always_comb begin
    stable_d = '0;
    clean_d  = clean_q;
    if (sync2_q != clean_q) begin
      if (stable_q == LAST) begin
        clean_d = sync2_q;
      end else begin
        stable_d = stable_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      stable_q   <= '0;
      clean_q    <= 1'b0;
      cleanDly_q <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      clean_q    <= clean_d;
      cleanDly_q <= clean_q;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = clean_q & ~cleanDly_q;

endmodule

// File: rtl/contador_multicanal.sv
// Multi-channel debounced object counter with batch stop FSM and LCD handshake.
// Optional PAUSE_EN adds a debounced pause_i toggle that holds the motor off.
module contador_multicanal
  import contador_pkg::*;
#(
  parameter  int unsigned CLOCK_FREQ  = 50_000_000,
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned CNT_W       = 8,
  parameter  int unsigned DEBOUNCE_MS = 10,
  parameter  int unsigned BATCH_SIZE  = 10,
  localparam int unsigned SEL_W       = selWidth(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH-1:0]        sensor_i,
  input  logic                   clear_i,
  input  logic                   batch_ack_i,
`ifdef PAUSE_EN
  input  logic                   pause_i,
`endif
  input  logic [SEL_W-1:0]       disp_sel_i,
  input  logic                   disp_ready_i,
  output logic                   disp_valid_o,
  output logic [CNT_W-1:0]       disp_data_o,
  output logic [CNT_W+SEL_W-1:0] total_o,
  output logic                   batch_done_o,
  output logic                   motor_run_o,
  output logic [N_CH-1:0]        sensor_clean_o
);

  localparam int unsigned     DEB_CYC = debCycles(CLOCK_FREQ, DEBOUNCE_MS);
  localparam int unsigned     TW      = CNT_W + SEL_W;
  localparam logic [TW-1:0]   BATCH_LIM = TW'(BATCH_SIZE);
  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned TOT_MAX = (64'd1 << TW) - 64'd1;

  logic [N_CH-1:0]  clean, rise;
  logic [SEL_W:0]   eventCnt;
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];
  logic [TW-1:0]    total_q, total_d;
  logic [TW-1:0]    batchCnt_q, batchCnt_d;
  batchState_e      state_q, state_d;
  logic             motorRun_q, motorRun_d;
  logic             batchDone_q, batchDone_d;
  logic             paused, pausedNext;
  logic [SEL_W-1:0] selEff, dataSel_q, dataSel_d, shadowSel_q, shadowSel_d;
  logic [CNT_W-1:0] liveData, dispData_q, dispData_d, shadowData_q, shadowData_d;
  logic             dispValid_q, dispValid_d;

  for (genvar g = 0; g < N_CH; g++) begin : gDeb
    antirrebote_sync #(.DEB_CYC(DEB_CYC)) uDeb (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (sensor_i[g]),
      .clean_o (clean[g]),
      .rise_o  (rise[g])
    );
  end

`ifdef PAUSE_EN
  logic pauseRise, pause_q, pause_d;

  antirrebote_sync #(.DEB_CYC(DEB_CYC)) uPause (
    .clk     (clk),
    .rst_n   (rst_n),
    .raw_i   (pause_i),
    .clean_o (),
    .rise_o  (pauseRise)
  );

  always_comb begin
    pause_d = pause_q;
    if (clear_i) pause_d = 1'b0;
    else if (pauseRise) pause_d = ~pause_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pause_q <= 1'b0;
    else        pause_q <= pause_d;
  end

  assign paused     = pause_q;
  assign pausedNext = pause_d;
`else
  assign paused     = 1'b0;
  assign pausedNext = 1'b0;
`endif

  always_comb begin
    eventCnt = '0;
    for (int i = 0; i < N_CH; i++) eventCnt = eventCnt + (SEL_W+1)'(rise[i]);
  end

  // Batch counter clamps at the limit, so it stays frozen while the FSM catches up
  always_comb begin
    total_d    = total_q;
    batchCnt_d = batchCnt_q;
    for (int i = 0; i < N_CH; i++) count_d[i] = count_q[i];
    if (clear_i) begin
      total_d    = '0;
      batchCnt_d = '0;
      for (int i = 0; i < N_CH; i++) count_d[i] = '0;
    end else begin
      for (int i = 0; i < N_CH; i++)
        if (rise[i]) count_d[i] = CNT_W'(satAdd(64'(count_q[i]), 64'd1, CNT_MAX));
      total_d = TW'(satAdd(64'(total_q), 64'(eventCnt), TOT_MAX));
      if (!paused) begin
        if (state_q == RUN)
          batchCnt_d = TW'(satAdd(64'(batchCnt_q), 64'(eventCnt), 64'(BATCH_SIZE)));
        else if (batch_ack_i)
          batchCnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = RUN;
    end else if (!paused) begin
      case (state_q)
        RUN:     if (batchCnt_q >= BATCH_LIM) state_d = FULL;
        FULL:    if (batch_ack_i) state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    motorRun_d  = (state_d == RUN) && !pausedNext;
    batchDone_d = (state_d == FULL);
  end

  assign selEff   = (32'(disp_sel_i) < N_CH) ? disp_sel_i : '0;
  assign liveData = count_q[selEff];

  // Data is frozen while offered but not accepted; otherwise it tracks the live count
  always_comb begin
    dispData_d   = dispData_q;
    dataSel_d    = dataSel_q;
    dispValid_d  = dispValid_q;
    shadowData_d = shadowData_q;
    shadowSel_d  = shadowSel_q;
    if (clear_i) begin
      dispData_d   = '0;
      dataSel_d    = selEff;
      dispValid_d  = 1'b0;
      shadowData_d = '0;
      shadowSel_d  = selEff;
    end else begin
      if (dispValid_q && disp_ready_i) begin
        shadowData_d = dispData_q;
        shadowSel_d  = dataSel_q;
      end
      if (!(dispValid_q && !disp_ready_i)) begin
        dispData_d  = liveData;
        dataSel_d   = selEff;
        dispValid_d = (liveData != shadowData_d) || (selEff != shadowSel_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      motorRun_q   <= 1'b0;
      batchDone_q  <= 1'b0;
      total_q      <= '0;
      batchCnt_q   <= '0;
      for (int i = 0; i < N_CH; i++) count_q[i] <= '0;
      dispData_q   <= '0;
      dataSel_q    <= '0;
      dispValid_q  <= 1'b0;
      shadowData_q <= '0;
      shadowSel_q  <= '0;
    end else begin
      state_q      <= state_d;
      motorRun_q   <= motorRun_d;
      batchDone_q  <= batchDone_d;
      total_q      <= total_d;
      batchCnt_q   <= batchCnt_d;
      for (int i = 0; i < N_CH; i++) count_q[i] <= count_d[i];
      dispData_q   <= dispData_d;
      dataSel_q    <= dataSel_d;
      dispValid_q  <= dispValid_d;
      shadowData_q <= shadowData_d;
      shadowSel_q  <= shadowSel_d;
    end
  end

  assign disp_valid_o   = dispValid_q;
  assign disp_data_o    = dispData_q;
  assign total_o        = total_q;
  assign batch_done_o   = batchDone_q;
  assign motor_run_o    = motorRun_q;
  assign sensor_clean_o = clean;

endmodule

// File: tb/tb_contador_multicanal.sv
// Directed self-checking bench for contador_multicanal (DEB_CYC=4, 4 channels, 4-bit counts, batch of 5).
// Display transfers are checked against a queue of expected values; PAUSE_EN adds the pause sequence.
module tb_contador_multicanal;

  localparam int N_CH  = 4;
  localparam int CNT_W = 4;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [N_CH-1:0]    sensor = '0;
  logic               clear = 1'b0;
  logic               ack = 1'b0;
`ifdef PAUSE_EN
  logic               pause = 1'b0;
`endif
  logic [SEL_W-1:0]   sel = '0;
  logic               ready = 1'b1;
  logic               valid;
  logic [CNT_W-1:0]   data;
  logic [CNT_W+SEL_W-1:0] total;
  logic               batchDone;
  logic               motorRun;
  logic [N_CH-1:0]    sensorClean;

  int checks = 0;
  int failures = 0;
  int unsigned expQ[$];
  bit scoreEn = 1'b0;

  contador_multicanal #(
    .CLOCK_FREQ  (1000),
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEBOUNCE_MS (4),
    .BATCH_SIZE  (5)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sensor_i       (sensor),
    .clear_i        (clear),
    .batch_ack_i    (ack),
`ifdef PAUSE_EN
    .pause_i        (pause),
`endif
    .disp_sel_i     (sel),
    .disp_ready_i   (ready),
    .disp_valid_o   (valid),
    .disp_data_o    (data),
    .total_o        (total),
    .batch_done_o   (batchDone),
    .motor_run_o    (motorRun),
    .sensor_clean_o (sensorClean)
  );

  always #5 clk = ~clk;

  // Every accepted display transfer must match the next queued expectation
  always @(negedge clk) begin
    if (scoreEn && valid && ready) begin
      checks++;
      assert (expQ.size() != 0) else begin
        failures++;
        $error("[TB] FAIL xferUnexpected observed=%0d expected=none", data);
      end
      if (expQ.size() != 0) begin
        int unsigned exp;
        exp = expQ.pop_front();
        checks++;
        assert (32'(data) === exp) else begin
          failures++;
          $error("[TB] FAIL xferData observed=%0d expected=%0d", data, exp);
        end
      end
    end
  end

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clean pulse: long enough high and low to pass the debouncer both ways
  task automatic applyStimulus(input logic [N_CH-1:0] mask);
    sensor = mask;
    stepCycles(8);
    sensor = '0;
    stepCycles(8);
  endtask

  task automatic pulseClear();
    clear = 1'b1;
    stepCycles(1);
    clear = 1'b0;
    stepCycles(1);
  endtask

`ifdef PAUSE_EN
  task automatic pulsePause();
    pause = 1'b1;
    stepCycles(8);
    pause = 1'b0;
    stepCycles(8);
  endtask
`endif

  initial begin
    $display("[TB] start");
    stepCycles(3);
    checkOutput("rstTotal", 32'(total), 0);
    checkOutput("rstMotor", 32'(motorRun), 0);
    checkOutput("rstDone", 32'(batchDone), 0);
    checkOutput("rstValid", 32'(valid), 0);
    checkOutput("rstClean", 32'(sensorClean), 0);
    rst_n = 1'b1;
    stepCycles(1);
    checkOutput("motorAfterRst", 32'(motorRun), 1);

    // Glitch of 3 cycles, 2 low, then 6 high
    sensor = 4'b0001;
    stepCycles(3);
    sensor = 4'b0000;
    stepCycles(2);
    sensor = 4'b0001;
    stepCycles(5);
    checkOutput("cleanBefore", 32'(sensorClean[0]), 0);
    stepCycles(1);
    checkOutput("cleanRise", 32'(sensorClean[0]), 1);
    checkOutput("totalBeforeEvt", 32'(total), 0);
    sensor = 4'b0000;
    stepCycles(1);
    checkOutput("totalAfterEvt", 32'(total), 1);
    stepCycles(12);
    checkOutput("glitchTotal", 32'(total), 1);
    checkOutput("glitchCount0", 32'(data), 1);

    // clear_i in the cycle of a ch0 event
    sensor = 4'b0001;
    stepCycles(6);
    clear = 1'b1;
    stepCycles(1);
    clear = 1'b0;
    sensor = 4'b0000;
    checkOutput("clrTotal", 32'(total), 0);
    stepCycles(1);
    checkOutput("clrValid", 32'(valid), 0);
    checkOutput("clrMotor", 32'(motorRun), 1);
    checkOutput("clrData", 32'(data), 0);
    stepCycles(12);
    checkOutput("clrTotalLater", 32'(total), 0);

    // Saturation on ch1
    sel = 2'd1;
    for (int i = 0; i < 20; i++) applyStimulus(4'b0010);
    checkOutput("satData", 32'(data), 15);
    checkOutput("satTotal", 32'(total), 20);
    checkOutput("satDone", 32'(batchDone), 1);
    checkOutput("satMotor", 32'(motorRun), 0);
    pulseClear();
    checkOutput("clrFullMotor", 32'(motorRun), 1);
    checkOutput("clrFullDone", 32'(batchDone), 0);
    checkOutput("clrFullData", 32'(data), 0);

    // Batch stop with simultaneous events
    sel = 2'd0;
    applyStimulus(4'b0101);
    applyStimulus(4'b0101);
    checkOutput("batch4Total", 32'(total), 4);
    checkOutput("batch4Motor", 32'(motorRun), 1);
    applyStimulus(4'b0101);
    checkOutput("batch6Total", 32'(total), 6);
    checkOutput("batch6Done", 32'(batchDone), 1);
    checkOutput("batch6Motor", 32'(motorRun), 0);
    applyStimulus(4'b0001);
    checkOutput("fullTotal", 32'(total), 7);
    checkOutput("fullDone", 32'(batchDone), 1);
    ack = 1'b1;
    checkOutput("ackPendMotor", 32'(motorRun), 0);
    stepCycles(1);
    ack = 1'b0;
    checkOutput("ackMotor", 32'(motorRun), 1);
    checkOutput("ackDone", 32'(batchDone), 0);

    // Display handshake with ready held low
    pulseClear();
    sel = 2'd3;
    stepCycles(4);
    ready = 1'b0;
    applyStimulus(4'b1000);
    checkOutput("hsValid1", 32'(valid), 1);
    checkOutput("hsData1", 32'(data), 1);
    applyStimulus(4'b1000);
    applyStimulus(4'b1000);
    checkOutput("hsHoldValid", 32'(valid), 1);
    checkOutput("hsHoldData", 32'(data), 1);
    checkOutput("hsTotal", 32'(total), 3);
    expQ.push_back(1);
    expQ.push_back(3);
    scoreEn = 1'b1;
    ready = 1'b1;
    stepCycles(5);
    scoreEn = 1'b0;
    checkOutput("hsValidDrop", 32'(valid), 0);
    checkOutput("hsQueueEmpty", 32'(expQ.size()), 0);

`ifdef PAUSE_EN
    pulsePause();
    checkOutput("pauseMotor", 32'(motorRun), 0);
    applyStimulus(4'b0100);
    checkOutput("pauseTotal", 32'(total), 4);
    checkOutput("pauseMotorHeld", 32'(motorRun), 0);
    pulsePause();
    checkOutput("resumeMotor", 32'(motorRun), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/contador_multicanal.md
Name: contador_multicanal

Overview:
Parametrised successor of the single-sensor object counter.
- Debounces N_CH raw infrared sensor inputs.
- Counts rising edges per channel with saturation and keeps a running total.
- Runs a batch state machine that stops the conveyor motor after BATCH_SIZE objects until the batch is acknowledged.
- Presents a selected channel count to the LCD controller over a valid/ready handshake.

Parameters:
CLOCK_FREQ, 50_000_000, system clock frequency in Hz
N_CH, 4, number of sensor channels (>=1)
CNT_W, 8, per-channel counter width
DEBOUNCE_MS, 10, required input stability time in ms
BATCH_SIZE, 10, objects per batch (1..2^(CNT_W+SEL_W)-1)
Derived constant: SEL_W = max(1,$clog2(N_CH))
Derived constant: DEB_CYC = CLOCK_FREQ/1000*DEBOUNCE_MS

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock, reset is synchronous and active-low
sensor_i  in  N_CH  raw sensor levels, asynchronous, high = object present
clear_i  in  1  synchronous clear of all counts
batch_ack_i  in  1  level; releases a full batch
disp_sel_i  in  SEL_W  channel shown on LCD; values >= N_CH select channel 0
disp_ready_i  in  1  LCD controller can accept data
disp_valid_o  out  1  disp_data_o holds a new value
disp_data_o  out  CNT_W  count of the selected channel
total_o  out  CNT_W+SEL_W  saturating sum of all accepted events
batch_done_o  out  1  batch full, waiting for ack
motor_run_o  out  1  conveyor enable
sensor_clean_o  out  N_CH  debounced sensor levels

Behaviour:
- Reset (rst_n=0 at a clk edge) clears all registers. All outputs are 0; FSM=RUN.
  - motor_run_o rises on the first clk after rst_n=1.
- Sensor path, per channel:
  - 2-flop synchroniser, then debouncer.
  - sensor_clean_o changes only after the synchronised input differs from it for DEB_CYC consecutive cycles.
  - Any glitch restarts the stability counter.
- Event: one-cycle pulse on each 0->1 of sensor_clean_o.
- Channel counter: +1 per event. Saturates at 2^CNT_W-1 with no wrap.
- total_o:
  - Adds the number of events in that cycle (0..N_CH); simultaneous events are all counted.
  - An event on a saturated channel is still counted.
  - total_o saturates at its all-ones value.
- Batch counter: internal, width of total_o.
- FSM:
  - RUN (motor_run_o=1): batch counter += events. When the result >= BATCH_SIZE, the counter clamps to BATCH_SIZE and the FSM enters FULL on the next edge. Excess events in that cycle are dropped from the batch but kept in the channel counters and total_o.
  - FULL (motor_run_o=0, batch_done_o=1): events still update the channel counters and total_o; the batch counter is frozen. batch_ack_i=1 -> RUN next cycle with batch counter=0.
  - An ack while in RUN is ignored.
- Outputs are registered. An edge on sensor_clean_o at cycle t gives:
  - count and total updated at t+1;
  - batch_done_o and motor_run_o change at t+2;
  - disp_valid_o at t+2.
- clear_i:
  - zeroes channel counters, total, batch counter and the display shadow, and forces RUN;
  - takes priority over same-cycle events, which are lost;
  - does not reset the debouncers.
- Display handshake:
  - A shadow register holds the last value transferred and the selection it came from.
  - disp_valid_o is set when the selected count or disp_sel_i differs from the shadow.
  - While valid=1 and ready=0, disp_data_o stays stable even if counts change.
  - On valid&ready the shadow is updated and valid drops next cycle, unless the live value already differs again.
  - After reset or clear_i, the shadow equals the live value (0), so valid=0.

Optional Feature:
PAUSE_EN
- Defined: adds input port pause_i (1 bit), conditioned by the same debounce sub-module.
  - Each rising edge of its clean level toggles a pause flag.
  - While paused, motor_run_o=0 and the FSM state is unchanged; events are still counted.
  - Reset and clear_i clear the flag.
- Undefined: no port and no logic; motor_run_o depends only on the FSM.

Decomposition:
- Package contador_pkg:
  - FSM enum type (RUN, FULL);
  - function computing DEB_CYC;
  - SEL_W helper function;
  - saturating-add function.
- Sub-module antirrebote_sync (synchroniser + debouncer + rise pulse, parameter DEB_CYC):
  - instantiated N_CH times;
  - plus once for pause_i when PAUSE_EN is defined.

Test Plan:
- Bench uses CLOCK_FREQ=1000, DEBOUNCE_MS=4 (DEB_CYC=4), N_CH=4, CNT_W=4, BATCH_SIZE=5.
- Glitch: pulse ch0 high for 3 cycles, then hold high for 6 cycles -> exactly one event; sensor_clean_o[0] rises 4 cycles after the stable level reaches the synchroniser output; count0=1.
- Saturation: 20 clean pulses on ch1 -> disp_data_o=15 with sel=1, total_o=20.
- Batch stop: pulses on ch0 and ch2 arrive in the same cycle, three times (6 events) -> batch_done_o=1, motor_run_o=0, total_o=6; a further event keeps FULL and gives total_o=7; one-cycle batch_ack_i -> RUN and motor_run_o=1 the following cycle.
- Handshake: disp_ready_i=0 while ch3 counts from 1 to 3 -> disp_data_o stays 1 with valid=1; raise ready -> transfer 1, then valid again with 3.
- clear_i in the same cycle as a ch0 event -> all counts 0, valid=0, FSM=RUN.
- PAUSE_EN: one pause_i pulse -> motor_run_o=0 while counts still increment; a second pulse -> motor_run_o=1.
